// File: rtl/vedic_div_8by4.sv
// vedic_div_8by4: sequential restoring divider, 2N-bit dividend by N-bit divisor.
// One subtract/shift step per clock, MSB first. Operands and results use
// valid/ready handshakes. A zero divisor skips the subtract steps and reports
// quotient = all ones, remainder = dividend[N-1:0] and div_zero = 1.
module vedic_div_8by4 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero
);

    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [2*N-1:0]   r_dvd;    // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N-1:0]     r_dvs;
    logic [N:0]       r_rem;    // partial remainder, one guard bit wide
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;   // accepted divisor was zero

    logic [N:0]       w_shift;
    logic             w_qbit;
    logic [N:0]       w_rem_nxt;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // NOTE: continuous assigns cover every bit on every path, so no latch can form here.
    assign w_shift   = {r_rem[N-1:0], r_dvd[2*N-1]};
    assign w_qbit    = (w_shift >= {1'b0, r_dvs});
    assign w_rem_nxt = w_qbit ? (w_shift - {1'b0, r_dvs}) : w_shift;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    // Control FSM, datapath registers and result registers.
    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_zero    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_zero  <= (divisor == '0);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_zero) begin
                        // Zero divisor: single pass-through cycle so out_valid rises after E1.
                        quotient  <= '1;
                        remainder <= r_dvd[N-1:0];
                        div_zero  <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= {r_dvd[2*N-2:0], w_qbit};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_STEP) begin
                            quotient  <= {r_dvd[2*N-2:0], w_qbit};
                            remainder <= w_rem_nxt[N-1:0];
                            div_zero  <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_div_8by4.sv
// tb_vedic_div_8by4: directed self-checking bench for the 8-by-4 restoring divider.
module tb_vedic_div_8by4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int n_cmp = 0;
    int n_err = 0;

    vedic_div_8by4 #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands before edge E0; returns #1 after E0.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Counts clocks from acceptance (E0 counts as 1) until out_valid; optional input noise.
    task automatic wait_done(input string tag, input int exp_lat, input bit noise);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                check("in_ready_low_in_calc", 32'(in_ready), 32'd0);
                in_valid = 1'($urandom);
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [3:0] r,
                                input logic z);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_quotient"}, 32'(quotient), 32'(q));
        check({tag, "_remainder"}, 32'(remainder), 32'(r));
        check({tag, "_div_zero"}, 32'(div_zero), 32'(z));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    // Holds out_ready low for 'hold' cycles, then completes the handshake.
    task automatic drain(input string tag, input int hold, input logic [7:0] q,
                         input logic [3:0] r, input logic z);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_bp_q"}, 32'({quotient, remainder, div_zero}), 32'({q, r, z}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_held"}, 32'({quotient, remainder, div_zero}), 32'({q, r, z}));
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] q, input logic [3:0] r, input logic z,
                          input int lat, input int hold, input bit noise);
        issue(a, b);
        wait_done(tag, lat, noise);
        check_result(tag, q, r, z);
        drain(tag, hold, q, r, z);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({quotient, remainder, div_zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic exact division, 9-clock latency.
        run_op("t143_11", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 9, 0, 1'b0);
        // Non-zero remainder and divide-by-one.
        run_op("t200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 0, 1'b0);
        run_op("t255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 0, 1'b0);
        // Dividend smaller than divisor.
        run_op("t5_13", 8'd5, 4'd13, 8'd0, 4'd5, 1'b0, 9, 0, 1'b0);
        // Divide by zero: 2-clock latency, all-ones quotient.
        run_op("tzero", 8'hB6, 4'd0, 8'hFF, 4'h6, 1'b1, 2, 0, 1'b0);
        // Backpressure for 5 cycles.
        run_op("t225_15", 8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 9, 5, 1'b0);
        // Random in_valid/operand noise during CALC is ignored.
        run_op("t100_9", 8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 9, 0, 1'b1);

        // Handshake coinciding with a new in_valid: accepted one cycle later.
        issue(8'd60, 4'd7);
        wait_done("t60_7", 9, 1'b0);
        check_result("t60_7", 8'd8, 4'd4, 1'b0);
        dividend  = 8'd143;
        divisor   = 4'd11;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("overlap_idle_in_ready", 32'(in_ready), 32'd1);
        check("overlap_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("overlap_accepted", 32'(in_ready), 32'd0);
        wait_done("overlap", 9, 1'b0);
        check_result("overlap", 8'd13, 4'd0, 1'b0);
        drain("overlap", 0, 8'd13, 4'd0, 1'b0);

        // Reset pulsed at CALC step 4 discards the operation.
        issue(8'd200, 4'd7);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'({quotient, remainder, div_zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale_valid", 32'(out_valid), 32'd0);
        end
        run_op("t9_2", 8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 9, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
